// File: rtl/rgmii_tx.sv
// RGMII transmit: AXI-Stream bytes in, preamble/SFD prepended, DDR nibbles out.
// 1G sends a byte per clock; 10/100 sends a nibble per clock on both DDR halves.
module rgmii_oddr (
  input  logic clk,
  input  logic rst_n,
  input  logic d1,
  input  logic d2,
  output logic q
);
  logic q1, q2;

  // SAME_EDGE: both halves are captured on the rising edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= d1;
      q2 <= d2;
    end

  assign q = clk ? q1 : q2;
endmodule

module rgmii_tx #(
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic       tx_mac_aclk,
  input  logic       tx_mac_aresetn,
  input  logic [1:0] clock_speed,
  input  logic [7:0] tx_axis_rgmii_tdata,
  input  logic       tx_axis_rgmii_tvalid,
  input  logic       tx_axis_rgmii_tlast,
  output logic       tx_axis_rgmii_tready,
  output logic       tx_underrun,
  output logic       rgmii_txc,
  output logic       rgmii_tx_ctl,
  output logic [3:0] rgmii_txd
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, ERR, DRAIN, IFG} state_t;

  localparam int CNT_MAX = (PREAMBLE_BYTES + 1 > IFG_BYTES) ? PREAMBLE_BYTES + 1 : IFG_BYTES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_BYTES);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_BYTES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          phase, byte_mode, hi_last;
  logic [3:0]    hi_nib;
  logic [3:0]    pos_d, neg_d;
  logic          pos_ctl, neg_ctl;
  logic          byte_end;
  logic [7:0]    pre_byte;

  assign byte_end = byte_mode | phase;
  assign pre_byte = (cnt == PRE_LAST) ? 8'hD5 : 8'h55;

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_aresetn) begin
    if (!tx_mac_aresetn) begin
      state                <= IDLE;
      cnt                  <= '0;
      phase                <= 1'b0;
      byte_mode            <= 1'b0;
      hi_last              <= 1'b0;
      hi_nib               <= '0;
      pos_d                <= '0;
      neg_d                <= '0;
      pos_ctl              <= 1'b0;
      neg_ctl              <= 1'b0;
      tx_axis_rgmii_tready <= 1'b0;
      tx_underrun          <= 1'b0;
    end else begin
      // idle pins unless a state below drives them
      pos_d                <= '0;
      neg_d                <= '0;
      pos_ctl              <= 1'b0;
      neg_ctl              <= 1'b0;
      tx_underrun          <= 1'b0;
      tx_axis_rgmii_tready <= 1'b0;
      phase                <= byte_mode ? 1'b0 : ~phase;

      case (state)
        IDLE: begin
          phase <= 1'b0;
          if (tx_axis_rgmii_tvalid) begin
            state     <= PRE;
            cnt       <= '0;
            byte_mode <= (clock_speed == 2'b10);
          end
        end

        PRE: begin
          pos_ctl <= 1'b1;
          neg_ctl <= 1'b1;
          if (byte_mode) begin
            pos_d <= pre_byte[3:0];
            neg_d <= pre_byte[7:4];
          end else begin
            pos_d <= phase ? pre_byte[7:4] : pre_byte[3:0];
            neg_d <= phase ? pre_byte[7:4] : pre_byte[3:0];
          end
          if (byte_end) begin
            cnt <= cnt + 1'b1;
            if (cnt == PRE_LAST) begin
              state                <= DATA;
              cnt                  <= '0;
              phase                <= 1'b0;
              tx_axis_rgmii_tready <= 1'b1;
            end
          end
        end

        DATA: begin
          if (tx_axis_rgmii_tready) begin
            if (tx_axis_rgmii_tvalid) begin
              pos_ctl <= 1'b1;
              neg_ctl <= 1'b1;
              pos_d   <= tx_axis_rgmii_tdata[3:0];
              neg_d   <= byte_mode ? tx_axis_rgmii_tdata[7:4] : tx_axis_rgmii_tdata[3:0];
              hi_nib  <= tx_axis_rgmii_tdata[7:4];
              hi_last <= tx_axis_rgmii_tlast;
              if (byte_mode) begin
                if (tx_axis_rgmii_tlast) begin
                  state <= IFG;
                  cnt   <= '0;
                end else begin
                  tx_axis_rgmii_tready <= 1'b1;
                end
              end
            end else begin
              // underrun: TX_EN high with TX_ER high marks the frame bad
              tx_underrun <= 1'b1;
              pos_ctl     <= 1'b1;
              phase       <= 1'b0;
              if (byte_mode) begin
                state                <= DRAIN;
                tx_axis_rgmii_tready <= 1'b1;
              end else begin
                state <= ERR;
              end
            end
          end else begin
            pos_ctl <= 1'b1;
            neg_ctl <= 1'b1;
            pos_d   <= hi_nib;
            neg_d   <= hi_nib;
            if (hi_last) begin
              state <= IFG;
              cnt   <= '0;
              phase <= 1'b0;
            end else begin
              tx_axis_rgmii_tready <= 1'b1;
            end
          end
        end

        ERR: begin
          pos_ctl              <= 1'b1;
          state                <= DRAIN;
          phase                <= 1'b0;
          tx_axis_rgmii_tready <= 1'b1;
        end

        DRAIN: begin
          tx_axis_rgmii_tready <= 1'b1;
          phase                <= 1'b0;
          if (tx_axis_rgmii_tvalid && tx_axis_rgmii_tlast) begin
            state                <= IFG;
            cnt                  <= '0;
            tx_axis_rgmii_tready <= 1'b0;
          end
        end

        IFG: begin
          if (byte_end) begin
            cnt <= cnt + 1'b1;
            if (cnt == IFG_LAST) begin
              state <= IDLE;
              phase <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_txd
    rgmii_oddr u_oddr (
      .clk  (tx_mac_aclk),
      .rst_n(tx_mac_aresetn),
      .d1   (pos_d[i]),
      .d2   (neg_d[i]),
      .q    (rgmii_txd[i])
    );
  end

  rgmii_oddr u_ctl (
    .clk  (tx_mac_aclk),
    .rst_n(tx_mac_aresetn),
    .d1   (pos_ctl),
    .d2   (neg_ctl),
    .q    (rgmii_tx_ctl)
  );

  // forwarded clock keeps running through reset
  rgmii_oddr u_txc (
    .clk  (tx_mac_aclk),
    .rst_n(1'b1),
    .d1   (1'b1),
    .d2   (1'b0),
    .q    (rgmii_txc)
  );
endmodule

// File: tb/tb_rgmii_tx.sv
// Directed bench for rgmii_tx: pins are logged per half-cycle, then frames are
// compared against hand-built preamble/data/IFG streams.
module tb_rgmii_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] clock_speed = 2'b10;
  logic [7:0] tdata = '0;
  logic       tvalid = 1'b0, tlast = 1'b0;
  logic       tready, tx_underrun, rgmii_txc, rgmii_tx_ctl;
  logic [3:0] rgmii_txd;

  rgmii_tx #(.IFG_BYTES(12), .PREAMBLE_BYTES(7)) dut (
    .tx_mac_aclk         (clk),
    .tx_mac_aresetn      (rst_n),
    .clock_speed         (clock_speed),
    .tx_axis_rgmii_tdata (tdata),
    .tx_axis_rgmii_tvalid(tvalid),
    .tx_axis_rgmii_tlast (tlast),
    .tx_axis_rgmii_tready(tready),
    .tx_underrun         (tx_underrun),
    .rgmii_txc           (rgmii_txc),
    .rgmii_tx_ctl        (rgmii_tx_ctl),
    .rgmii_txd           (rgmii_txd)
  );

  always #4 clk = ~clk;

  localparam int LOG = 4096;
  int         cyc = 0;
  int         n_vec = 0, n_bad = 0;
  int         acc_e = 0;
  logic       p_ctl[LOG], n_ctl[LOG], p_txc[LOG], n_txc[LOG], rdy[LOG], und[LOG];
  logic [3:0] p_d[LOG], n_d[LOG];
  logic [7:0] exp_bytes[16];
  int         exp_n = 0;

  // index = number of rising edges seen; high half then low half of that cycle
  always @(posedge clk) begin
    #1;
    if (cyc < LOG - 1) cyc++;
    p_ctl[cyc] = rgmii_tx_ctl;
    p_d[cyc]   = rgmii_txd;
    p_txc[cyc] = rgmii_txc;
    rdy[cyc]   = tready;
    und[cyc]   = tx_underrun;
  end

  always @(negedge clk) begin
    #1;
    n_ctl[cyc] = rgmii_tx_ctl;
    n_d[cyc]   = rgmii_txd;
    n_txc[cyc] = rgmii_txc;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got cycle %0d required < 50000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ones(input bit sel_und, input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) n += sel_und ? int'(und[i] === 1'b1) : int'(rdy[i] === 1'b1);
    return n;
  endfunction

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic put_byte(input logic [7:0] d, input logic last);
    int n = 0;
    tdata  = d;
    tvalid = 1'b1;
    tlast  = last;
    while (tready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("handshake timeout", 32'(n), 32'(0));
    @(negedge clk);
  endtask

  task automatic send_frame(input bit hold);
    for (int j = 0; j < exp_n; j++) put_byte(exp_bytes[j], j == exp_n - 1);
    acc_e = cyc;
    if (!hold) begin
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input int n);
    exp_bytes[0] = b0; exp_bytes[1] = b1; exp_bytes[2] = b2;
    exp_bytes[3] = b3; exp_bytes[4] = b4; exp_n = n;
  endtask

  task automatic check_frame(input int from, input bit nib, input bit err, input string tag,
                             output int i0, output int last);
    int bt, idx;
    logic [7:0] b;
    logic [3:0] lo, hi;
    bt = nib ? 2 : 1;
    i0 = -1;
    for (int i = from; i < cyc; i++)
      if (i0 < 0 && p_ctl[i] === 1'b1) i0 = i;
    chk({tag, " sof found"}, 32'(i0 >= 0), 32'(1));
    if (i0 < 0) begin
      last = from;
    end else begin
      for (int k = 0; k < 8 + exp_n; k++) begin
        if (k < 7) b = 8'h55;
        else if (k == 7) b = 8'hD5;
        else b = exp_bytes[k-8];
        for (int h = 0; h < bt; h++) begin
          idx = i0 + k * bt + h;
          lo  = (nib && h == 1) ? b[7:4] : b[3:0];
          hi  = nib ? lo : b[7:4];
          chk($sformatf("%s pins byte%0d half%0d", tag, k, h),
              {p_ctl[idx], n_ctl[idx], p_d[idx], n_d[idx]}, {2'b11, lo, hi});
        end
        if (k >= 8) begin
          chk($sformatf("%s tready before byte%0d", tag, k - 8), rdy[i0 + k * bt - 2], 1);
          if (nib) chk($sformatf("%s tready low mid byte%0d", tag, k - 8), rdy[i0 + k * bt - 1], 0);
        end
      end
      last = i0 + (8 + exp_n) * bt - 1;
      if (err) begin
        last++;
        chk({tag, " error pin"}, {p_ctl[last], n_ctl[last], p_d[last], n_d[last]}, 10'b10_0000_0000);
        chk({tag, " underrun pulse"}, und[last-1], 1);
      end
      for (int j = 1; j <= 12 * bt; j++)
        chk($sformatf("%s idle +%0d", tag, j),
            {p_ctl[last+j], n_ctl[last+j], p_d[last+j], n_d[last+j]}, 0);
      chk({tag, " underrun count"}, 32'(ones(1'b1, i0, last + 12 * bt)), 32'(err));
    end
  endtask

  initial begin
    int i0, l0, i1, l1, r0, s;

    // reset state
    repeat (4) @(negedge clk);
    chk("reset tready", tready, 0);
    chk("reset underrun", tx_underrun, 0);
    chk("reset pins low half", {rgmii_tx_ctl, rgmii_txd}, 0);
    chk("reset pins high half", {p_ctl[3], p_d[3]}, 0);
    chk("reset txc high half", p_txc[3], 1);
    chk("reset txc low half", n_txc[3], 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1G frame
    clock_speed = 2'b10;
    set_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 4);
    s = cyc;
    send_frame(1'b0);
    repeat (40) @(negedge clk);
    check_frame(s, 1'b0, 1'b0, "1g", i0, l0);
    chk("1g ctl cycles", 32'(l0 - i0 + 1), 32'(12));
    chk("1g ifg tready", 32'(ones(1'b0, acc_e, acc_e + 12)), 32'(0));

    // nibble mode
    clock_speed = 2'b01;
    s = cyc;
    send_frame(1'b0);
    repeat (60) @(negedge clk);
    check_frame(s, 1'b1, 1'b0, "nib", i0, l0);
    chk("nib ctl cycles", 32'(l0 - i0 + 1), 32'(24));
    chk("nib ifg tready", 32'(ones(1'b0, acc_e, acc_e + 24)), 32'(0));

    // underrun at 1G after byte 2 of 5
    clock_speed = 2'b10;
    set_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 2);
    s = cyc;
    put_byte(8'hA1, 1'b0);
    put_byte(8'hB2, 1'b0);
    tvalid = 1'b0;
    @(negedge clk);
    put_byte(8'hC3, 1'b0);
    put_byte(8'hD4, 1'b0);
    put_byte(8'hE5, 1'b1);
    acc_e = cyc;
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (40) @(negedge clk);
    check_frame(s, 1'b0, 1'b1, "urun", i0, l0);
    chk("urun drain ends then ifg", 32'(acc_e - l0), 32'(2));
    chk("urun ifg tready", 32'(ones(1'b0, acc_e, acc_e + 12)), 32'(0));

    // back-to-back, tvalid held across both frames
    s = cyc;
    set_frame(8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 2);
    send_frame(1'b1);
    set_frame(8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 2);
    send_frame(1'b0);
    repeat (40) @(negedge clk);
    set_frame(8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 2);
    check_frame(s, 1'b0, 1'b0, "b2b f1", i0, l0);
    set_frame(8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 2);
    check_frame(l0 + 1, 1'b0, 1'b0, "b2b f2", i1, l1);
    chk("b2b idle gap", 32'(i1 - l0 - 1), 32'(13));

    // reset during DATA
    put_byte(8'h01, 1'b0);
    put_byte(8'h02, 1'b0);
    put_byte(8'h03, 1'b0);
    rst_n  = 1'b0;
    tvalid = 1'b0;
    r0 = cyc;
    repeat (4) @(negedge clk);
    for (int i = r0 + 1; i <= r0 + 3; i++) begin
      chk($sformatf("midrst pins %0d", i - r0), {p_ctl[i], n_ctl[i], p_d[i], n_d[i]}, 0);
      chk($sformatf("midrst tready %0d", i - r0), rdy[i], 0);
      chk($sformatf("midrst txc %0d", i - r0), {p_txc[i], n_txc[i]}, 2'b10);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst no underrun", 32'(ones(1'b1, r0 - 3, cyc)), 32'(0));
    set_frame(8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 2);
    s = cyc;
    send_frame(1'b0);
    repeat (30) @(negedge clk);
    check_frame(s, 1'b0, 1'b0, "after rst", i0, l0);

    // speed change mid-frame: current frame stays 1G, next goes nibble
    clock_speed = 2'b10;
    s = cyc;
    put_byte(8'h12, 1'b0);
    clock_speed = 2'b00;
    put_byte(8'h34, 1'b0);
    put_byte(8'h56, 1'b1);
    set_frame(8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00, 2);
    send_frame(1'b0);
    repeat (70) @(negedge clk);
    set_frame(8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 3);
    check_frame(s, 1'b0, 1'b0, "spd f1", i0, l0);
    set_frame(8'h9A, 8'hBC, 8'h00, 8'h00, 8'h00, 2);
    check_frame(l0 + 1, 1'b1, 1'b0, "spd f2", i1, l1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
